// File: rtl/geofence_poly.sv
// -----------------------------------------------------------------------------
// geofence_poly
// Point-in-convex-polygon tester. A frame is NV+1 accepted beats: the target
// point followed by NV polygon vertices in any order. The vertices are sorted
// counter-clockwise around vertex 0, the target is tested against every edge,
// and the result is reported with a one-cycle valid strobe.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   X/Y beat valid
//   in_ready   block can accept a beat (high only while collecting)
//   X, Y       unsigned coordinates of the current beat
//   valid      one-cycle result strobe
//   is_inside  containment result, qualified by valid, held until next strobe
//   on_edge    target lies on an edge, qualified by valid, held until next strobe
//   busy       frame being processed (sort, check or output)
// -----------------------------------------------------------------------------
module geofence_poly #(
    parameter int COORD_W      = 10,
    parameter int NV           = 6,
    parameter bit INCLUDE_EDGE = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] X,
    input  logic [COORD_W-1:0] Y,
    output logic               valid,
    output logic               is_inside,
    output logic               on_edge,
    output logic               busy
);

    localparam int DW = COORD_W + 1;      // coordinate difference width
    localparam int PW = 2 * COORD_W + 2;  // product width
    localparam int CW = 2 * COORD_W + 3;  // cross-product width
    localparam int IW = $clog2(NV);       // vertex index width
    localparam int BW = $clog2(NV + 1);   // beat counter width

    typedef enum logic [1:0] {COLLECT, SORT, CHECK, OUT} state_t;

    state_t             state_q, state_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [IW-1:0]      i_q, i_d, j_q, j_d, k_q, k_d;
    logic [COORD_W-1:0] vx_q [NV];
    logic [COORD_W-1:0] vx_d [NV];
    logic [COORD_W-1:0] vy_q [NV];
    logic [COORD_W-1:0] vy_d [NV];
    logic [COORD_W-1:0] tx_q, tx_d, ty_q, ty_d;
    // Edge signs are kept as three sticky flags: the verdict depends only on
    // which signs occurred, not on which edge produced them.
    logic               any_pos_q, any_pos_d, any_neg_q, any_neg_d;
    logic               any_zero_q, any_zero_d;
    logic               is_inside_q, is_inside_d, on_edge_q, on_edge_d;

    logic [IW-1:0]        k_next;
    logic signed [DW-1:0] ax, ay, bx, by;
    logic signed [CW-1:0] c;

    function automatic logic signed [DW-1:0] diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    // Full-width a x b; widened before every operation so nothing truncates.
    function automatic logic signed [CW-1:0] cross_prod(input logic signed [DW-1:0] pax,
                                                        input logic signed [DW-1:0] pay,
                                                        input logic signed [DW-1:0] pbx,
                                                        input logic signed [DW-1:0] pby);
        logic signed [PW-1:0] p1, p2;
        p1 = PW'(pax) * PW'(pby);
        p2 = PW'(pay) * PW'(pbx);
        return CW'(p1) - CW'(p2);
    endfunction

    // One shared cross-product unit: sort compares in SORT, edge tests in CHECK.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        k_next = (k_q == IW'(NV - 1)) ? '0 : k_q + 1'b1;
        ax     = diff(vx_q[i_q], vx_q[0]);
        ay     = diff(vy_q[i_q], vy_q[0]);
        bx     = diff(vx_q[j_q], vx_q[0]);
        by     = diff(vy_q[j_q], vy_q[0]);
        if (state_q == CHECK) begin
            ax = diff(vx_q[k_q], tx_q);
            ay = diff(vy_q[k_q], ty_q);
            bx = diff(vx_q[k_next], vx_q[k_q]);
            by = diff(vy_q[k_next], vy_q[k_q]);
        end
        c = cross_prod(ax, ay, bx, by);
    end

    always_comb begin
        logic c_pos, c_neg, c_zero, f_pos, f_neg, f_zero, mixed;
        state_d     = state_q;
        beat_d      = beat_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        any_pos_d   = any_pos_q;
        any_neg_d   = any_neg_q;
        any_zero_d  = any_zero_q;
        is_inside_d = is_inside_q;
        on_edge_d   = on_edge_q;

        c_zero = (c == '0);
        c_neg  = c[CW-1];
        c_pos  = !c_zero && !c_neg;
        // Flags including the current edge; the first edge restarts them.
        f_pos  = c_pos  | ((k_q != '0) & any_pos_q);
        f_neg  = c_neg  | ((k_q != '0) & any_neg_q);
        f_zero = c_zero | ((k_q != '0) & any_zero_q);
        mixed  = f_pos & f_neg;

        unique case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    if (beat_q == '0) begin
                        tx_d = X;
                        ty_d = Y;
                    end else begin
                        vx_d[beat_q - 1'b1] = X;
                        vy_d[beat_q - 1'b1] = Y;
                    end
                    if (beat_q == BW'(NV)) begin
                        beat_d  = '0;
                        i_d     = IW'(1);
                        j_d     = IW'(2);
                        state_d = SORT;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            SORT: begin
                // v[j] clockwise of v[i] around v[0]: bring it forward.
                if (c_neg) begin
                    vx_d[i_q] = vx_q[j_q];
                    vx_d[j_q] = vx_q[i_q];
                    vy_d[i_q] = vy_q[j_q];
                    vy_d[j_q] = vy_q[i_q];
                end
                if (j_q == IW'(NV - 1)) begin
                    if (i_q == IW'(NV - 2)) begin
                        k_d     = '0;
                        state_d = CHECK;
                    end else begin
                        i_d = i_q + 1'b1;
                        j_d = i_q + IW'(2);
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            CHECK: begin
                any_pos_d  = f_pos;
                any_neg_d  = f_neg;
                any_zero_d = f_zero;
                if (k_q == IW'(NV - 1)) begin
                    on_edge_d   = f_zero & !mixed;
                    is_inside_d = (!f_zero & !mixed) | (INCLUDE_EDGE & f_zero & !mixed);
                    state_d     = OUT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            OUT: begin
                state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= COLLECT;
            beat_q      <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            any_pos_q   <= 1'b0;
            any_neg_q   <= 1'b0;
            any_zero_q  <= 1'b0;
            is_inside_q <= 1'b0;
            on_edge_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            any_pos_q   <= any_pos_d;
            any_neg_q   <= any_neg_d;
            any_zero_q  <= any_zero_d;
            is_inside_q <= is_inside_d;
            on_edge_q   <= on_edge_d;
        end
    end

    // NOTE: point storage is deliberately not reset; every frame overwrites it before use.
    always_ff @(posedge clk) begin
        vx_q <= vx_d;
        vy_q <= vy_d;
        tx_q <= tx_d;
        ty_q <= ty_d;
    end

    assign in_ready  = (state_q == COLLECT);
    assign busy      = (state_q != COLLECT);
    assign valid     = (state_q == OUT);
    assign is_inside = is_inside_q;
    assign on_edge   = on_edge_q;

endmodule

// File: tb/tb_geofence_poly.sv
// -----------------------------------------------------------------------------
// tb_geofence_poly
// Directed bench for geofence_poly. Two hexagon instances (NV=6, COORD_W=10)
// share stimulus and differ only in INCLUDE_EDGE; a third instance (NV=3,
// COORD_W=12) checks the triangle cases at full coordinate range.
// -----------------------------------------------------------------------------
module tb_geofence_poly;

    logic        clk = 1'b0;
    logic        reset;
    logic        iv_h, iv_t;
    logic [9:0]  x_h, y_h;
    logic [11:0] x_t, y_t;
    logic        rdy_a, valid_a, in_a, edge_a, busy_a;
    logic        rdy_b, valid_b, in_b, edge_b, busy_b;
    logic        rdy_t, valid_t, in_t, edge_t, busy_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_pulse_h = 0, n_pulse_t = 0, n_frame_h = 0, n_frame_t = 0;

    typedef struct {
        int cyc;
        bit va, ia, ea, vb, ib, eb;
    } res_t;
    res_t q_h[$];
    res_t q_t[$];

    int hex_shuf_x[8] = '{200, 0, 200, 300, 100, 100, 0, 0};
    int hex_shuf_y[8] = '{200, 100, 0, 100, 0, 200, 0, 0};
    int hex_cw_x[8]   = '{100, 0, 100, 200, 300, 200, 0, 0};
    int hex_cw_y[8]   = '{0, 100, 200, 200, 100, 0, 0, 0};
    int tri_sw_x[8]   = '{0, 0, 4095, 0, 0, 0, 0, 0};
    int tri_sw_y[8]   = '{0, 4095, 0, 0, 0, 0, 0, 0};
    int tri_x[8]      = '{0, 4095, 0, 0, 0, 0, 0, 0};
    int tri_y[8]      = '{0, 0, 4095, 0, 0, 0, 0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    geofence_poly #(.COORD_W(10), .NV(6), .INCLUDE_EDGE(1'b0)) dut_a (
        .clk(clk), .reset(reset), .in_valid(iv_h), .in_ready(rdy_a), .X(x_h), .Y(y_h),
        .valid(valid_a), .is_inside(in_a), .on_edge(edge_a), .busy(busy_a));

    geofence_poly #(.COORD_W(10), .NV(6), .INCLUDE_EDGE(1'b1)) dut_b (
        .clk(clk), .reset(reset), .in_valid(iv_h), .in_ready(rdy_b), .X(x_h), .Y(y_h),
        .valid(valid_b), .is_inside(in_b), .on_edge(edge_b), .busy(busy_b));

    geofence_poly #(.COORD_W(12), .NV(3), .INCLUDE_EDGE(1'b0)) dut_t (
        .clk(clk), .reset(reset), .in_valid(iv_t), .in_ready(rdy_t), .X(x_t), .Y(y_t),
        .valid(valid_t), .is_inside(in_t), .on_edge(edge_t), .busy(busy_t));

    // Result monitors: every cycle with a strobe is logged.
    always @(negedge clk) begin
        if (!reset && (valid_a || valid_b)) begin
            q_h.push_back('{cyc, valid_a, in_a, edge_a, valid_b, in_b, edge_b});
            n_pulse_h++;
        end
        if (!reset && valid_t) begin
            q_t.push_back('{cyc, valid_t, in_t, edge_t, 1'b0, 1'b0, 1'b0});
            n_pulse_t++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one beat and hold it until the handshake accepts it; c is the
    // cycle in which it is accepted.
    task automatic send_beat(input bit sel, input int x, input int y, output int c);
        int n = 0;
        @(negedge clk);
        if (sel) begin iv_t = 1'b1; x_t = 12'(x); y_t = 12'(y); end
        else     begin iv_h = 1'b1; x_h = 10'(x); y_h = 10'(y); end
        while (!(sel ? rdy_t : rdy_a) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            $display("FAIL ready_timeout: in_ready stuck low for %0d cycles", n);
            $fatal(1);
        end
        c = cyc;
    endtask

    task automatic idle(input bit sel);
        @(negedge clk);
        if (sel) begin iv_t = 1'b0; x_t = 12'hABC; y_t = 12'h123; end
        else     begin iv_h = 1'b0; x_h = 10'h2A5; y_h = 10'h15A; end
    endtask

    task automatic send_frame(input bit sel, input int tx, input int ty,
                              input int vx[8], input int vy[8], input int nv,
                              input bit gaps, output int t_first, output int t_last);
        send_beat(sel, tx, ty, t_first);
        for (int b = 0; b < nv; b++) begin
            if (gaps && (b % 2 == 0)) repeat ((b % 3) + 1) idle(sel);
            send_beat(sel, vx[b], vy[b], t_last);
        end
    endtask

    task automatic expect_res(input bit sel, input int t_last, input int lat,
                              input bit e_in_a, input bit e_edge_a,
                              input bit e_in_b, input bit e_edge_b, input string tag);
        int   n = 0;
        res_t r;
        while ((sel ? q_t.size() : q_h.size()) == 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".pulse"}, int'((sel ? q_t.size() : q_h.size()) > 0), 1);
        if ((sel ? q_t.size() : q_h.size()) > 0) begin
            r = sel ? q_t.pop_front() : q_h.pop_front();
            check({tag, ".latency"}, r.cyc - t_last, lat);
            check({tag, ".in_a"}, int'(r.ia), int'(e_in_a));
            check({tag, ".edge_a"}, int'(r.ea), int'(e_edge_a));
            if (!sel) begin
                check({tag, ".valid_a"}, int'(r.va), 1);
                check({tag, ".valid_b"}, int'(r.vb), 1);
                check({tag, ".in_b"}, int'(r.ib), int'(e_in_b));
                check({tag, ".edge_b"}, int'(r.eb), int'(e_edge_b));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int tf, tl, tf2, tl2;
        reset = 1'b1;
        iv_h = 1'b0; x_h = '0; y_h = '0;
        iv_t = 1'b0; x_t = '0; y_t = '0;
        repeat (2) @(negedge clk);
        check("rst.valid_a", int'(valid_a), 0);
        check("rst.in_a", int'(in_a), 0);
        check("rst.edge_a", int'(edge_a), 0);
        check("rst.busy_a", int'(busy_a), 0);
        check("rst.rdy_a", int'(rdy_a), 1);
        check("rst.rdy_b", int'(rdy_b), 1);
        check("rst.rdy_t", int'(rdy_t), 1);
        check("rst.valid_t", int'(valid_t), 0);
        reset = 1'b0;

        // Shuffled hexagon, target inside.
        send_frame(1'b0, 150, 100, hex_shuf_x, hex_shuf_y, 6, 1'b0, tf, tl);
        idle(1'b0);
        check("sort.busy", int'(busy_a), 1);
        check("sort.rdy", int'(rdy_a), 0);
        expect_res(1'b0, tl, 17, 1, 0, 1, 0, "hex_inside");
        n_frame_h++;

        // Target outside.
        send_frame(1'b0, 400, 100, hex_shuf_x, hex_shuf_y, 6, 1'b0, tf, tl);
        idle(1'b0);
        expect_res(1'b0, tl, 17, 0, 0, 0, 0, "hex_outside");
        n_frame_h++;

        // Clockwise input order gives identical results.
        send_frame(1'b0, 150, 100, hex_cw_x, hex_cw_y, 6, 1'b0, tf, tl);
        idle(1'b0);
        expect_res(1'b0, tl, 17, 1, 0, 1, 0, "cw_inside");
        n_frame_h++;
        send_frame(1'b0, 400, 100, hex_cw_x, hex_cw_y, 6, 1'b0, tf, tl);
        idle(1'b0);
        expect_res(1'b0, tl, 17, 0, 0, 0, 0, "cw_outside");
        n_frame_h++;

        // Target on the bottom edge: inside only when edges count.
        send_frame(1'b0, 150, 0, hex_shuf_x, hex_shuf_y, 6, 1'b0, tf, tl);
        idle(1'b0);
        expect_res(1'b0, tl, 17, 0, 1, 1, 1, "on_edge");
        n_frame_h++;

        // Target at a vertex, with input gaps inside the frame.
        send_frame(1'b0, 300, 100, hex_shuf_x, hex_shuf_y, 6, 1'b1, tf, tl);
        idle(1'b0);
        expect_res(1'b0, tl, 17, 0, 1, 1, 1, "at_vertex_gaps");
        n_frame_h++;

        // Back-to-back: in_valid stays high with the next target while busy.
        send_frame(1'b0, 400, 100, hex_shuf_x, hex_shuf_y, 6, 1'b0, tf, tl);
        send_frame(1'b0, 200, 100, hex_cw_x, hex_cw_y, 6, 1'b0, tf2, tl2);
        idle(1'b0);
        check("b2b.next_accept", tf2 - tl, 18);
        expect_res(1'b0, tl, 17, 0, 0, 0, 0, "b2b_first");
        expect_res(1'b0, tl2, 17, 1, 0, 1, 0, "b2b_second");
        n_frame_h += 2;

        // Reset mid-SORT aborts the frame and clears held outputs.
        send_frame(1'b0, 400, 100, hex_shuf_x, hex_shuf_y, 6, 1'b0, tf, tl);
        idle(1'b0);
        repeat (3) @(negedge clk);
        check("hold.in_a", int'(in_a), 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort.in_a", int'(in_a), 0);
        check("abort.in_b", int'(in_b), 0);
        check("abort.valid_a", int'(valid_a), 0);
        check("abort.busy_a", int'(busy_a), 0);
        check("abort.rdy_a", int'(rdy_a), 1);
        reset = 1'b0;
        send_frame(1'b0, 150, 0, hex_cw_x, hex_cw_y, 6, 1'b1, tf, tl);
        idle(1'b0);
        expect_res(1'b0, tl, 17, 0, 1, 1, 1, "after_reset");
        n_frame_h++;

        // Triangle at the 12-bit range limits.
        send_frame(1'b1, 1000, 1000, tri_sw_x, tri_sw_y, 3, 1'b0, tf, tl);
        idle(1'b1);
        expect_res(1'b1, tl, 5, 1, 0, 0, 0, "tri_inside");
        send_frame(1'b1, 4095, 4095, tri_x, tri_y, 3, 1'b0, tf, tl);
        idle(1'b1);
        expect_res(1'b1, tl, 5, 0, 0, 0, 0, "tri_outside");
        send_frame(1'b1, 2048, 2047, tri_x, tri_y, 3, 1'b1, tf, tl);
        idle(1'b1);
        expect_res(1'b1, tl, 5, 0, 1, 0, 0, "tri_edge");
        n_frame_t += 3;

        // Exactly one strobe per completed frame, none from the aborted one.
        repeat (30) @(negedge clk);
        check("hex.pulses", n_pulse_h, n_frame_h);
        check("tri.pulses", n_pulse_t, n_frame_t);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/geofence_poly.md
Name: geofence_poly

Overview:
Point-in-convex-polygon tester, parametrised in coordinate width and vertex count. It is the next generation of the team's 6-vertex, 10-bit geofence block.
- Accepts one target point, then NV unordered polygon vertices, over a valid/ready stream.
- Sorts the vertices into counter-clockwise order around vertex 0 using cross-product compares.
- Checks the target against every edge, then reports inside / on-edge with a one-cycle result pulse.
- Sits between the coordinate-fetch stage and the alarm/event logger.

Parameters:
COORD_W, 10, unsigned coordinate width in bits (legal 4..16)
NV, 6, polygon vertex count (legal 3..8)
INCLUDE_EDGE, 0, 1 = a target lying on a polygon edge counts as inside

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  X/Y beat valid
in_ready  output  1  block can accept a beat
X  input  COORD_W  unsigned x coordinate
Y  input  COORD_W  unsigned y coordinate
valid  output  1  one-cycle result strobe
is_inside  output  1  containment result, qualified by valid
on_edge  output  1  target lies on a polygon edge, qualified by valid
busy  output  1  frame being processed (SORT, CHECK or OUT)

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous, active-high.
- Reset values: valid=0, is_inside=0, on_edge=0, busy=0, in_ready=1; state=COLLECT; beat counter=0.
- Reset at any point, including mid-SORT or mid-CHECK, aborts the frame; no valid pulse is produced for that frame.
- Frame: NV+1 accepted beats. A beat is accepted when in_valid && in_ready.
  - Beat 0 is the target.
  - Beats 1..NV are stored as v[0..NV-1].
  - Gaps with in_valid=0 are allowed and do not advance the counter.
- States:
  - COLLECT: in_ready=1. Go to SORT on the cycle the NV-th vertex is accepted.
  - SORT: in_ready=0. One compare per cycle over pairs (i,j), 1<=i<j<=NV-1, i outer loop, j inner loop. P=(NV-1)(NV-2)/2 cycles (10 for NV=6). Per pair:
    - c = cross(v[i]-v[0], v[j]-v[0]).
    - If c<0, swap v[i] and v[j] in the same cycle.
    - The next compare sees the updated array.
    - Go to CHECK after the last pair.
  - CHECK: NV cycles, k=0..NV-1. Per edge:
    - e[k] = cross(v[k]-T, v[(k+1) mod NV]-v[k]).
    - Record a 2-bit sign for e[k]: pos, neg or zero.
  - OUT: one cycle. valid=1 with registered is_inside/on_edge. Return to COLLECT; in_ready is 1 on the next cycle.
- Latency: if the last vertex is accepted at cycle t, valid is high at cycle t+P+NV+1 (t+17 for NV=6). The result is independent of input gaps after frame completion.
- Arithmetic:
  - Coordinate differences are signed COORD_W+1 bits.
  - Products are signed 2*COORD_W+2 bits.
  - The cross difference is signed 2*COORD_W+3 bits.
  - No truncation anywhere; the full COORD_W range must be exact.
- Result:
  - strict = no zero signs and all signs equal.
  - on_edge = at least one zero sign and all non-zero signs equal.
  - is_inside = strict | (INCLUDE_EDGE & on_edge).
  - Outside otherwise: is_inside=0, on_edge=0.
  - Both outputs hold their values until the next valid pulse and read 0 after reset.
- Input constraints, not checked: polygon is strictly convex; no three vertices are collinear; vertices are distinct. Behaviour on violation is undefined but must not hang; latency is unchanged.
- in_valid asserted while in_ready=0 is ignored and not buffered. Upstream must hold the beat.
- Back-to-back frames: the first beat of the next frame may be accepted the cycle after OUT.

Test Plan:
- Hexagon (100,0),(200,0),(300,100),(200,200),(100,200),(0,100) presented shuffled as (200,200),(0,100),(200,0),(300,100),(100,0),(100,200); target (150,100) -> valid at t+17, is_inside=1, on_edge=0.
- Same vertices, target (400,100) -> is_inside=0, on_edge=0. Same vertices in clockwise input order -> identical result.
- Target (150,0) -> on_edge=1; is_inside=0 with INCLUDE_EDGE=0, is_inside=1 with INCLUDE_EDGE=1. Target at vertex (300,100) -> on_edge=1.
- Random in_valid gaps inside a frame; in_valid held high throughout busy; two frames back-to-back -> exactly one valid pulse per frame, no beats absorbed while busy, correct results for both frames.
- Reset asserted mid-SORT, then a full new frame -> no pulse from the aborted frame; new result correct; outputs 0 right after reset.
- NV=3, COORD_W=12: triangle (0,0),(4095,0),(0,4095); targets (1000,1000) -> inside; (4095,4095) -> outside; (2048,2047) -> on_edge=1. Valid at t+5.
